// File: rtl/ifetch_unit_if.sv
// Instruction-memory fetch port: req/addr out, gnt/rvalid/rdata back.
// master = fetch unit, slave = instruction memory.
interface ifetch_unit_if #(
  parameter int AW = 32
) ();
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// Fetch stage: issues PC_F to imem (one outstanding), fills IF/ID, drives stall_F.
// Ports: clk, rst_n, PC_F, PC_src, stall_D, stall_F, imem (master), instr_D, PC_D, valid_D.
// Optional IFETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module ifetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          AW        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] PC_F,
  input  logic          PC_src,
  input  logic          stall_D,
  output logic          stall_F,
  ifetch_unit_if.master imem,
  output logic [31:0]   instr_D,
  output logic [AW-1:0] PC_D,
  output logic          valid_D
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          kill_q, kill_d;
  logic [AW-1:0] pend_q, pend_d;
  logic [31:0]   skid_q, skid_d;

  logic          ld;
  logic [31:0]   ld_instr;
  logic          fetch_done;

  always_comb begin
    state_d        = state_q;
    kill_d         = kill_q;
    pend_d         = pend_q;
    skid_d         = skid_q;
    ld             = 1'b0;
    ld_instr       = skid_q;
    imem.imem_req  = (state_q == S_REQ);
    imem.imem_addr = PC_F;

    unique case (state_q)
      S_REQ: begin
        if (imem.imem_gnt) begin
          pend_d  = PC_F;
          state_d = S_WAIT;
          // redirect in the grant cycle: the word is already stale
          kill_d  = PC_src;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (kill_q || PC_src) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (!stall_D) begin
            ld       = 1'b1;
            ld_instr = imem.imem_rdata;
            state_d  = S_REQ;
          end else begin
            skid_d  = imem.imem_rdata;
            state_d = S_HOLD;
          end
        end else if (PC_src) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (PC_src) begin
          state_d = S_REQ;
        end else if (!stall_D) begin
          ld       = 1'b1;
          ld_instr = skid_q;
          state_d  = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    fetch_done = ld;
    // PC moves on a redirect or once per delivered word
    stall_F    = ~PC_src & ~fetch_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      kill_q  <= 1'b0;
      pend_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pend_q  <= pend_d;
      skid_q  <= skid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_D <= NOP_INSTR;
      PC_D    <= '0;
      valid_D <= 1'b0;
    end else if (PC_src) begin
      instr_D <= NOP_INSTR;
      PC_D    <= '0;
      valid_D <= 1'b0;
    end else if (ld) begin
      instr_D <= ld_instr;
      PC_D    <= pend_q;
      valid_D <= 1'b1;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + {31'd0, fetch_done};
      perf_stall_cnt <= perf_stall_cnt + {31'd0, stall_F};
    end
  end
`endif

`ifndef SYNTHESIS
  a_rvalid_in_wait: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem.imem_rvalid |-> (state_q == S_WAIT)
  );
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: random memory latency, stalls, redirects,
// checked cycle by cycle against a transaction-level model.
module tb_ifetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] PC_F;
  logic        PC_src;
  logic        stall_D;
  logic        stall_F;
  logic [31:0] instr_D;
  logic [31:0] PC_D;
  logic        valid_D;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ifetch_unit_if #(.AW(32)) imem ();

  always #5 clk = ~clk;

  ifetch_unit #(.NOP_INSTR(NOP), .AW(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .PC_F    (PC_F),
    .PC_src  (PC_src),
    .stall_D (stall_D),
    .stall_F (stall_F),
    .imem    (imem.master),
    .instr_D (instr_D),
    .PC_D    (PC_D),
    .valid_D (valid_D)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  // memory side
  logic        mb;
  int          mc;
  logic [31:0] ma;
  // model: outstanding request, buffered word, IF/ID contents
  logic        m_out, m_kill, m_buf;
  logic [31:0] m_addr, m_bw, m_bpc;
  logic [31:0] e_instr, e_pc;
  logic        e_valid;
  logic [31:0] e_fc, e_sc;
  logic [31:0] pc_nxt;

  initial begin
    logic        rv, g, e_req, dlv, e_stf;
    logic [31:0] dw, dpc, tgt;
    int          phase;
    PC_src = 1'b0;
    stall_D = 1'b0;
    imem.imem_gnt = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = '0;
    PC_F = 32'h8000_0000;
    pc_nxt = 32'h8000_0000;
    mb = 1'b0; mc = 0; ma = '0;
    m_out = 1'b0; m_kill = 1'b0; m_buf = 1'b0;
    m_addr = '0; m_bw = '0; m_bpc = '0;
    e_instr = NOP; e_pc = '0; e_valid = 1'b0;
    e_fc = '0; e_sc = '0;

    repeat (3) @(negedge clk);
    chk("rst_instr", instr_D, NOP);
    chk("rst_pc", PC_D, 32'h0);
    chk("rst_valid", {31'd0, valid_D}, 32'd0);
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      phase = cyc / 1000;
      PC_F = pc_nxt;
      rv = mb && (mc == 0);
      imem.imem_rvalid = rv;
      imem.imem_rdata = rv ? word_at(ma) : $urandom;
      if (phase == 0) begin
        PC_src = 1'b0;
        stall_D = 1'b0;
        g = imem.imem_req;
      end else begin
        PC_src = ($urandom_range(0, 99) < 7);
        stall_D = ($urandom_range(0, 99) < 30 * phase / 2);
        g = imem.imem_req && ($urandom_range(0, 99) < 60);
      end
      imem.imem_gnt = g;
      tgt = $urandom & 32'hFFFF_FFFC;

      e_req = !m_out && !m_buf;
      dlv = 1'b0; dw = '0; dpc = '0;
      if (!PC_src && !stall_D) begin
        if (m_out && rv && !m_kill) begin
          dlv = 1'b1; dw = word_at(m_addr); dpc = m_addr;
        end else if (m_buf) begin
          dlv = 1'b1; dw = m_bw; dpc = m_bpc;
        end
      end
      e_stf = !PC_src && !dlv;

      #1;
      chk("req", {31'd0, imem.imem_req}, {31'd0, e_req});
      if (e_req) chk("addr", imem.imem_addr, PC_F);
      chk("stall_F", {31'd0, stall_F}, {31'd0, e_stf});
      chk("instr_D", instr_D, e_instr);
      chk("PC_D", PC_D, e_pc);
      chk("valid_D", {31'd0, valid_D}, {31'd0, e_valid});
`ifdef IFETCH_PERF_EN
      chk("perf_fetch", perf_fetch_cnt, e_fc);
      chk("perf_stall", perf_stall_cnt, e_sc);
`endif

      if (PC_src) begin
        e_instr = NOP; e_pc = '0; e_valid = 1'b0;
        m_buf = 1'b0;
        if (m_out) begin
          if (rv) begin m_out = 1'b0; m_kill = 1'b0; end
          else m_kill = 1'b1;
        end
      end else begin
        if (m_out && rv) begin
          m_out = 1'b0;
          if (!m_kill && stall_D) begin
            m_buf = 1'b1; m_bw = word_at(m_addr); m_bpc = m_addr;
          end
          m_kill = 1'b0;
        end else if (m_buf && !stall_D) begin
          m_buf = 1'b0;
        end
        if (dlv) begin
          e_instr = dw; e_pc = dpc; e_valid = 1'b1;
        end
      end
      if (g) begin
        m_out = 1'b1; m_kill = PC_src; m_addr = PC_F;
      end
      e_fc = e_fc + {31'd0, dlv};
      e_sc = e_sc + {31'd0, e_stf};

      if (rv) mb = 1'b0;
      else if (mb) mc--;
      if (g) begin
        mb = 1'b1;
        ma = imem.imem_addr;
        mc = (phase == 0) ? 0 : $urandom_range(0, 3);
      end

      if (!stall_F) pc_nxt = PC_src ? tgt : PC_F + 32'd4;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
